// File: rtl/snake_dir_ctrl.sv
// PS/2 keycode to snake-direction controller: decodes arrow/WASD/Space/R, queues turns, releases one per tick.
// All outputs registered; a tick at cycle N yields step/dir at N+1; a turn that arrives while the queue is full is counted in drop_cnt and discarded.
module snake_dir_ctrl #(
  parameter int         QDEPTH      = 2,
  parameter logic [1:0] INIT_DIR    = 2'b01,
  parameter bit         ENABLE_WASD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [15:0] keycode,
  input  logic        tick,
  output logic [1:0]  dir,
  output logic        step,
  output logic        paused,
  output logic        restart,
  output logic [2:0]  q_count,
  output logic [7:0]  drop_cnt
);

  localparam int            PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);
  localparam logic [2:0]    FULL = 3'(QDEPTH);

  logic [7:0]    prev_byte;
  logic [7:0]    new_byte;
  logic          prev_plain;
  logic          turn_vld;
  logic [1:0]    turn_dir;
  logic          space_make;
  logic          r_make;

  logic [1:0]    mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] tail_idx;
  logic [1:0]    ref_dir;
  logic          accept;
  logic          run_tick;
  logic          pop;
  logic          push;
  logic          drop;
  logic          flush;
  logic          full;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign prev_byte  = keycode[15:8];
  assign new_byte   = keycode[7:0];
  assign prev_plain = (prev_byte != 8'hE0) && (prev_byte != 8'hF0);

  // Prefix bytes (E0/F0) in the newest slot never match any case item below.
  always_comb begin
    turn_vld   = 1'b0;
    turn_dir   = 2'b00;
    space_make = 1'b0;
    r_make     = 1'b0;
    if (key_valid) begin
      if (prev_byte == 8'hE0) begin
        case (new_byte)
          8'h75:   begin turn_vld = 1'b1; turn_dir = 2'b00; end
          8'h74:   begin turn_vld = 1'b1; turn_dir = 2'b01; end
          8'h72:   begin turn_vld = 1'b1; turn_dir = 2'b10; end
          8'h6B:   begin turn_vld = 1'b1; turn_dir = 2'b11; end
          default: ;
        endcase
      end else if (prev_plain) begin
        case (new_byte)
          8'h1D:   begin turn_vld = ENABLE_WASD; turn_dir = 2'b00; end
          8'h23:   begin turn_vld = ENABLE_WASD; turn_dir = 2'b01; end
          8'h1B:   begin turn_vld = ENABLE_WASD; turn_dir = 2'b10; end
          8'h1C:   begin turn_vld = ENABLE_WASD; turn_dir = 2'b11; end
          8'h29:   space_make = 1'b1;
          8'h2D:   r_make     = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // New turns are judged against the last queued turn, so a burst cannot sneak in a reversal.
  assign tail_idx = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
  assign ref_dir  = (q_count != 3'd0) ? mem[tail_idx] : dir;
  assign accept   = turn_vld && !paused &&
                    (turn_dir != ref_dir) && (turn_dir != (ref_dir ^ 2'b10));
  assign run_tick = tick && !paused && !r_make;
  assign pop      = run_tick && (q_count != 3'd0);
  assign full     = (q_count == FULL);
  assign push     = accept && (!full || pop);
  assign drop     = accept && full && !pop;
  assign flush    = space_make || r_make;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= turn_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir      <= INIT_DIR;
      step     <= 1'b0;
      paused   <= 1'b0;
      restart  <= 1'b0;
      q_count  <= 3'd0;
      drop_cnt <= 8'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      step    <= run_tick;
      restart <= r_make;

      if (r_make) begin
        paused <= 1'b0;
      end else if (space_make) begin
        paused <= ~paused;
      end

      if (r_make) begin
        dir <= INIT_DIR;
      end else if (pop) begin
        dir <= mem[rd_ptr];
      end

      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end

      // A pop alongside Space still takes effect on dir; the flush then empties the rest.
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        q_count <= 3'd0;
      end else begin
        if (push) begin
          wr_ptr <= next_ptr(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= next_ptr(rd_ptr);
        end
        case ({push, pop})
          2'b10:   q_count <= q_count + 3'd1;
          2'b01:   q_count <= q_count - 3'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with default parameters (QDEPTH=2, INIT_DIR=01, WASD on).
module tb_snake_dir_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [15:0] keycode;
  logic        tick;
  logic [1:0]  dir;
  logic        step;
  logic        paused;
  logic        restart;
  logic [2:0]  q_count;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  snake_dir_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .keycode  (keycode),
    .tick     (tick),
    .dir      (dir),
    .step     (step),
    .paused   (paused),
    .restart  (restart),
    .q_count  (q_count),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p, input logic [7:0] c, input logic with_tick);
    key_valid = 1'b1;
    keycode   = {p, c};
    tick      = with_tick;
    cyc();
    key_valid = 1'b0;
    keycode   = 16'h0000;
    tick      = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; keycode = 16'h0000; tick = 1'b0;
    #1;
    cyc(); cyc();
    check("rst_dir", 32'(dir), 32'h1);
    check("rst_step", 32'(step), 32'h0);
    check("rst_paused", 32'(paused), 32'h0);
    check("rst_restart", 32'(restart), 32'h0);
    check("rst_qcount", 32'(q_count), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    rst = 1'b0;
    cyc();

    // Plain tick with empty queue
    do_tick();
    check("t1_step", 32'(step), 32'h1);
    check("t1_dir", 32'(dir), 32'h1);
    check("t1_q", 32'(q_count), 32'h0);
    cyc();
    check("t1_step_clear", 32'(step), 32'h0);

    // Up accepted, then down rejected as reversal of queued up
    send(8'hE0, 8'h75, 1'b0);
    check("t2_q_up", 32'(q_count), 32'h1);
    send(8'hE0, 8'h72, 1'b0);
    check("t2_q_rev", 32'(q_count), 32'h1);
    do_tick();
    check("t2_dir1", 32'(dir), 32'h0);
    check("t2_step1", 32'(step), 32'h1);
    check("t2_q_after", 32'(q_count), 32'h0);
    do_tick();
    check("t2_dir2", 32'(dir), 32'h0);

    // Back to right, then up/left queued and down dropped as full
    send(8'hE0, 8'h74, 1'b0);
    do_tick();
    check("t3_dir_right", 32'(dir), 32'h1);
    send(8'hE0, 8'h75, 1'b0);
    send(8'hE0, 8'h6B, 1'b0);
    check("t3_q_full", 32'(q_count), 32'h2);
    send(8'hE0, 8'h72, 1'b0);
    check("t3_q_drop", 32'(q_count), 32'h2);
    check("t3_drop_cnt", 32'(drop_cnt), 32'h1);
    do_tick();
    check("t3_dir_a", 32'(dir), 32'h0);
    do_tick();
    check("t3_dir_b", 32'(dir), 32'h3);
    check("t3_q_empty", 32'(q_count), 32'h0);

    // Typematic repeat of up while heading left
    for (int i = 0; i < 5; i++) send(8'hE0, 8'h75, 1'b0);
    check("t4_typematic_q", 32'(q_count), 32'h1);
    check("t4_drop_same", 32'(drop_cnt), 32'h1);
    do_tick();
    check("t4_dir", 32'(dir), 32'h0);

    // Pause flushes, blocks ticks and turns; Space again resumes
    send(8'hE0, 8'h74, 1'b0);
    check("t5_q_pre", 32'(q_count), 32'h1);
    send(8'h00, 8'h29, 1'b0);
    check("t5_paused", 32'(paused), 32'h1);
    check("t5_flush", 32'(q_count), 32'h0);
    do_tick();
    check("t5_no_step", 32'(step), 32'h0);
    check("t5_dir_hold", 32'(dir), 32'h0);
    send(8'hE0, 8'h6B, 1'b0);
    check("t5_turn_ignored", 32'(q_count), 32'h0);
    send(8'h00, 8'h29, 1'b0);
    check("t5_unpaused", 32'(paused), 32'h0);

    // Full queue: push and tick together keeps occupancy, no drop
    send(8'hE0, 8'h74, 1'b0);
    send(8'hE0, 8'h72, 1'b0);
    check("t6_q_full", 32'(q_count), 32'h2);
    send(8'hE0, 8'h6B, 1'b1);
    check("t6_q_same", 32'(q_count), 32'h2);
    check("t6_drop_same", 32'(drop_cnt), 32'h1);
    check("t6_dir_pop", 32'(dir), 32'h1);
    check("t6_step", 32'(step), 32'h1);
    do_tick();
    check("t6_dir_down", 32'(dir), 32'h2);
    do_tick();
    check("t6_dir_left", 32'(dir), 32'h3);

    // R during tick with a queued turn
    send(8'hE0, 8'h75, 1'b0);
    check("t6_q_r_pre", 32'(q_count), 32'h1);
    send(8'h00, 8'h2D, 1'b1);
    check("t6_restart", 32'(restart), 32'h1);
    check("t6_r_step", 32'(step), 32'h0);
    check("t6_r_dir", 32'(dir), 32'h1);
    check("t6_r_q", 32'(q_count), 32'h0);
    cyc();
    check("t6_restart_clear", 32'(restart), 32'h0);

    // W break and a lone E0 change nothing; W make steers up
    send(8'hF0, 8'h1D, 1'b0);
    send(8'h00, 8'hE0, 1'b0);
    check("t7_q", 32'(q_count), 32'h0);
    check("t7_dir", 32'(dir), 32'h1);
    check("t7_paused", 32'(paused), 32'h0);
    check("t7_drop", 32'(drop_cnt), 32'h1);
    check("t7_restart", 32'(restart), 32'h0);
    send(8'h00, 8'h1D, 1'b0);
    check("t7_w_q", 32'(q_count), 32'h1);
    do_tick();
    check("t7_w_dir", 32'(dir), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
